pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline registers (PC, IF/ID, ID/EX, EX/MEM).
//  - Detects load-use hazards and inserts bubbles.
//  - Squashes wrong-path instructions on a taken branch.
//  - Freezes the whole pipe while a data-memory access waits for its ack.

---
 rtl/hazard_ctrl_pkg.sv | 15 +
 rtl/hazard_perf_cnt.sv | 30 +++
 rtl/pipeline_hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// State encoding, zero-register id and perf counter width.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2,
        BUBBLE   = 2'd3
    } hz_state_e;

    localparam logic [4:0] ZERO_REG = 5'd0;
    localparam int         PERF_W   = 32;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Free-running wrapping perf counters: stall cycles and taken-branch flush sequences.
// Instantiated by pipeline_hazard_ctrl only when HAZARD_PERF_EN is defined.
module hazard_perf_cnt
    import hazard_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_inc_i,
    input  logic              flush_inc_i,
    output logic [PERF_W-1:0] stall_cycles_o,
    output logic [PERF_W-1:0] flush_count_o
);

    logic [PERF_W-1:0] r_stall_cycles;
    logic [PERF_W-1:0] r_flush_count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (stall_inc_i) r_stall_cycles <= r_stall_cycles + 1'b1;
            if (flush_inc_i) r_flush_count  <= r_flush_count + 1'b1;
        end
    end

    assign stall_cycles_o = r_stall_cycles;
    assign flush_count_o  = r_flush_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW         = 5,
    parameter int BRANCH_PENALTY = 1,
    parameter int MEM_TIMEOUT    = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              ex_mem_read_i,
    input  logic [REG_AW-1:0] ex_rt_i,
    input  logic              branch_taken_i,
    input  logic              mem_req_i,
    input  logic              mem_ack_i,
    output logic              pc_stall_o,
    output logic              if_id_stall_o,
    output logic              if_id_flush_o,
    output logic              id_ex_stall_o,
    output logic              id_ex_flush_o,
    output logic              ex_mem_stall_o,
    output logic              mem_timeout_o,
    output logic [PERF_W-1:0] stall_cycles_o,
    output logic [PERF_W-1:0] flush_count_o
);

    localparam logic [2:0]  PEN_M1 = 3'(BRANCH_PENALTY - 1);
    localparam logic [15:0] TMO    = 16'(MEM_TIMEOUT);

    hz_state_e   r_state, w_state_next;
    logic [15:0] r_wait_cnt, w_wait_next;
    logic [2:0]  r_remaining, w_rem_next;
    logic        r_timeout, w_timeout_next;
    logic        w_lu, w_mem_stall;
    logic        w_pc_stall, w_if_id_stall, w_if_id_flush;
    logic        w_id_ex_stall, w_id_ex_flush, w_ex_mem_stall;

    assign w_lu = ex_mem_read_i && (ex_rt_i != REG_AW'(ZERO_REG)) &&
                  ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));
    assign w_mem_stall = mem_req_i && !mem_ack_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_remaining <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_wait_cnt  <= w_wait_next;
            r_remaining <= w_rem_next;
            r_timeout   <= w_timeout_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_wait_next    = r_wait_cnt;
        w_rem_next     = r_remaining;
        w_timeout_next = r_timeout;
        w_pc_stall     = 1'b0;
        w_if_id_stall  = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_stall  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_ex_mem_stall = 1'b0;
        case (r_state)
            RUN, BUBBLE: begin
                if (w_mem_stall) begin
                    {w_pc_stall, w_if_id_stall, w_id_ex_stall, w_ex_mem_stall} = 4'hF;
                    w_state_next = MEM_WAIT;
                    w_wait_next  = 16'd1;
                end else if (branch_taken_i) begin
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                    w_rem_next    = PEN_M1;
                    w_state_next  = (PEN_M1 != 3'd0) ? FLUSH : RUN;
                end else if (r_state == RUN && w_lu) begin
                    w_pc_stall    = 1'b1;
                    w_if_id_stall = 1'b1;
                    w_id_ex_flush = 1'b1;
                    w_state_next  = BUBBLE;
                end else begin
                    w_state_next = RUN;
                end
            end
            MEM_WAIT: begin
                // A flush interrupted by the stall resumes once the access completes.
                if (mem_ack_i) begin
                    w_state_next = (r_remaining != 3'd0) ? FLUSH : RUN;
                end else if (r_wait_cnt == TMO) begin
                    w_timeout_next = 1'b1;
                    w_rem_next     = 3'd0;
                    w_state_next   = RUN;
                end else begin
                    {w_pc_stall, w_if_id_stall, w_id_ex_stall, w_ex_mem_stall} = 4'hF;
                    w_wait_next = r_wait_cnt + 16'd1;
                end
            end
            FLUSH: begin
                if (w_mem_stall) begin
                    {w_pc_stall, w_if_id_stall, w_id_ex_stall, w_ex_mem_stall} = 4'hF;
                    w_state_next = MEM_WAIT;
                    w_wait_next  = 16'd1;
                end else begin
                    w_if_id_flush = 1'b1;
                    w_rem_next    = r_remaining - 3'd1;
                    if (r_remaining <= 3'd1) w_state_next = RUN;
                end
            end
            default: w_state_next = RUN;
        endcase
    end

    assign pc_stall_o     = w_pc_stall     && !rst_i;
    assign if_id_stall_o  = w_if_id_stall  && !rst_i;
    assign if_id_flush_o  = w_if_id_flush  && !rst_i;
    assign id_ex_stall_o  = w_id_ex_stall  && !rst_i;
    assign id_ex_flush_o  = w_id_ex_flush  && !rst_i;
    assign ex_mem_stall_o = w_ex_mem_stall && !rst_i;
    assign mem_timeout_o  = r_timeout;

`ifdef HAZARD_PERF_EN
    logic w_branch_entry;
    assign w_branch_entry = ((r_state == RUN) || (r_state == BUBBLE)) &&
                            !w_mem_stall && branch_taken_i;

    hazard_perf_cnt u_perf (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .stall_inc_i    (w_pc_stall),
        .flush_inc_i    (w_branch_entry),
        .stall_cycles_o (stall_cycles_o),
        .flush_count_o  (flush_count_o)
    );
`else
    assign stall_cycles_o = '0;
    assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (BRANCH_PENALTY=2, MEM_TIMEOUT=4).
// Expected per-cycle outputs are queued when driven and compared on the falling edge.
module tb_pipeline_hazard_ctrl;
    import hazard_ctrl_pkg::*;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // ctrl bit order: pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall
    localparam logic [5:0] NONE  = 6'b000000;
    localparam logic [5:0] STALL = 6'b110101;
    localparam logic [5:0] LU    = 6'b110010;
    localparam logic [5:0] BR    = 6'b001010;
    localparam logic [5:0] F1    = 6'b001000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [4:0]  id_rs_i = '0, id_rt_i = '0, ex_rt_i = '0;
    logic        ex_mem_read_i = 1'b0, branch_taken_i = 1'b0;
    logic        mem_req_i = 1'b0, mem_ack_i = 1'b0;
    logic        pc_stall_o, if_id_stall_o, if_id_flush_o;
    logic        id_ex_stall_o, id_ex_flush_o, ex_mem_stall_o, mem_timeout_o;
    logic [31:0] stall_cycles_o, flush_count_o;

    typedef struct {
        string       tag;
        logic [5:0]  ctrl;
        logic        to;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] m_sc = 0, m_fc = 0;

    pipeline_hazard_ctrl #(
        .REG_AW(5), .BRANCH_PENALTY(2), .MEM_TIMEOUT(4)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .ex_mem_read_i(ex_mem_read_i), .ex_rt_i(ex_rt_i),
        .branch_taken_i(branch_taken_i),
        .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
        .pc_stall_o(pc_stall_o), .if_id_stall_o(if_id_stall_o),
        .if_id_flush_o(if_id_flush_o), .id_ex_stall_o(id_ex_stall_o),
        .id_ex_flush_o(id_ex_flush_o), .ex_mem_stall_o(ex_mem_stall_o),
        .mem_timeout_o(mem_timeout_o),
        .stall_cycles_o(stall_cycles_o), .flush_count_o(flush_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    always @(negedge clk_i) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            $display("txn %-12s ctrl=%b to=%b sc=%0d fc=%0d", e.tag,
                     {pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o,
                      id_ex_flush_o, ex_mem_stall_o}, mem_timeout_o,
                     stall_cycles_o, flush_count_o);
            check_val({e.tag, ".ctrl"}, 32'({pc_stall_o, if_id_stall_o, if_id_flush_o,
                      id_ex_stall_o, id_ex_flush_o, ex_mem_stall_o}), 32'(e.ctrl));
            check_val({e.tag, ".timeout"}, 32'(mem_timeout_o), 32'(e.to));
            check_val({e.tag, ".stall_cnt"}, stall_cycles_o, e.sc);
            check_val({e.tag, ".flush_cnt"}, flush_count_o, e.fc);
        end
    end

    // One clock of stimulus; fe marks a taken-branch flush entry this cycle.
    task automatic step(input string tag, input logic rst, input logic lr,
                        input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt,
                        input logic bt, input logic mreq, input logic mack,
                        input logic [5:0] ectrl, input logic fe, input logic eto);
        exp_t e;
        rst_i = rst; ex_mem_read_i = lr; ex_rt_i = ert; id_rs_i = rs; id_rt_i = rt;
        branch_taken_i = bt; mem_req_i = mreq; mem_ack_i = mack;
        if (rst) begin
            m_sc = 0;
            m_fc = 0;
        end
        e.tag = tag; e.ctrl = ectrl; e.to = eto;
        e.sc = PERF ? m_sc : 32'd0;
        e.fc = PERF ? m_fc : 32'd0;
        sb_q.push_back(e);
        m_sc = m_sc + 32'(ectrl[5]);
        m_fc = m_fc + 32'(fe);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        @(posedge clk_i);
        #1;
        step("rst_hold",  1, 1, 5, 5, 0, 0, 0, 0, NONE,  0, 0);
        step("rst_hold2", 1, 0, 0, 0, 0, 0, 0, 0, NONE,  0, 0);
        // load-use on rs, masked in BUBBLE, re-detected afterwards
        step("lu_rs",     0, 1, 5, 5, 0, 0, 0, 0, LU,    0, 0);
        step("lu_mask",   0, 1, 5, 5, 0, 0, 0, 0, NONE,  0, 0);
        step("lu_again",  0, 1, 5, 5, 0, 0, 0, 0, LU,    0, 0);
        step("bub_idle",  0, 0, 0, 0, 0, 0, 0, 0, NONE,  0, 0);
        step("idle",      0, 0, 0, 0, 0, 0, 0, 0, NONE,  0, 0);
        step("lu_rt",     0, 1, 7, 3, 7, 0, 0, 0, LU,    0, 0);
        step("lu_rt_bub", 0, 0, 0, 0, 0, 0, 0, 0, NONE,  0, 0);
        step("lu_r0",     0, 1, 0, 0, 0, 0, 0, 0, NONE,  0, 0);
        step("no_load",   0, 0, 5, 5, 0, 0, 0, 0, NONE,  0, 0);
        // taken branch with two-cycle penalty
        step("br",        0, 0, 0, 0, 0, 1, 0, 0, BR,    1, 0);
        step("br_f1",     0, 0, 0, 0, 0, 0, 0, 0, F1,    0, 0);
        step("br_done",   0, 0, 0, 0, 0, 0, 0, 0, NONE,  0, 0);
        step("lu_pre_br", 0, 1, 9, 9, 0, 0, 0, 0, LU,    0, 0);
        step("br_in_bub", 0, 0, 0, 0, 0, 1, 0, 0, BR,    1, 0);
        step("bub_br_f1", 0, 0, 0, 0, 0, 0, 0, 0, F1,    0, 0);
        step("bub_br_end",0, 0, 0, 0, 0, 0, 0, 0, NONE,  0, 0);
        // memory wait, ack on the fourth cycle
        step("mw0",       0, 0, 0, 0, 0, 0, 1, 0, STALL, 0, 0);
        step("mw1",       0, 0, 0, 0, 0, 0, 1, 0, STALL, 0, 0);
        step("mw2",       0, 0, 0, 0, 0, 0, 1, 0, STALL, 0, 0);
        step("mw_ack",    0, 0, 0, 0, 0, 0, 1, 1, NONE,  0, 0);
        step("ack_same",  0, 0, 0, 0, 0, 0, 1, 1, NONE,  0, 0);
        step("mw_idle",   0, 0, 0, 0, 0, 0, 0, 0, NONE,  0, 0);
        // stall preempts an in-progress flush, flush resumes afterwards
        step("pre_br",    0, 0, 0, 0, 0, 1, 0, 0, BR,    1, 0);
        step("pre_req",   0, 0, 0, 0, 0, 0, 1, 0, STALL, 0, 0);
        step("pre_wait",  0, 0, 0, 0, 0, 0, 1, 0, STALL, 0, 0);
        step("pre_ack",   0, 0, 0, 0, 0, 0, 1, 1, NONE,  0, 0);
        step("pre_resume",0, 0, 0, 0, 0, 0, 0, 0, F1,    0, 0);
        step("pre_done",  0, 0, 0, 0, 0, 0, 0, 0, NONE,  0, 0);
        // branch and load-use ignored while waiting on memory
        step("ig_req",    0, 0, 0, 0, 0, 0, 1, 0, STALL, 0, 0);
        step("ig_wait",   0, 1, 6, 6, 0, 1, 1, 0, STALL, 0, 0);
        step("ig_ack",    0, 0, 0, 0, 0, 0, 1, 1, NONE,  0, 0);
        step("ig_run",    0, 0, 0, 0, 0, 0, 0, 0, NONE,  0, 0);
        // timeout after four waiting cycles, sticky afterwards
        step("to0",       0, 0, 0, 0, 0, 0, 1, 0, STALL, 0, 0);
        step("to1",       0, 0, 0, 0, 0, 0, 1, 0, STALL, 0, 0);
        step("to2",       0, 0, 0, 0, 0, 0, 1, 0, STALL, 0, 0);
        step("to3",       0, 0, 0, 0, 0, 0, 1, 0, STALL, 0, 0);
        step("to_hit",    0, 0, 0, 0, 0, 0, 1, 0, NONE,  0, 0);
        step("to_sticky", 0, 0, 0, 0, 0, 0, 0, 0, NONE,  0, 1);
        step("to_sticky2",0, 0, 0, 0, 0, 0, 0, 0, NONE,  0, 1);
        // asynchronous reset in the middle of MEM_WAIT
        step("rs_req",    0, 0, 0, 0, 0, 0, 1, 0, STALL, 0, 1);
        step("rs_wait",   0, 0, 0, 0, 0, 0, 1, 0, STALL, 0, 1);
        step("rs_pulse",  1, 0, 0, 0, 0, 0, 1, 0, NONE,  0, 0);
        step("rs_rel",    0, 0, 0, 0, 0, 0, 0, 0, NONE,  0, 0);
        step("rs_lu",     0, 1, 4, 0, 4, 0, 0, 0, LU,    0, 0);
        step("rs_end",    0, 0, 0, 0, 0, 0, 0, 0, NONE,  0, 0);
        check_val("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation did not complete");
    end

endmodule
